// File: rtl/mem_access_sequencer_if.sv
// mem_access_sequencer_if
//   Groups the ControlUnit/RAM-facing signals of the load/store sequencer.
//   master : environment side (ControlUnit request, RAM MFC), consumes the strobes.
//   slave  : the sequencer itself.
//   Request : start, op3[5:0], addr_lo[2:0]; RAM handshake : MFC.
//   Strobes : MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, RAM_OpCode[5:0],
//             register_file_enable, addr_inc, word_sel.
//   Status  : busy, done, trap, trap_type[1:0].
interface mem_access_sequencer_if;
    logic       start;
    logic [5:0] op3;
    logic [2:0] addr_lo;
    logic       MFC;
    logic       MAR_Enable;
    logic       MDR_Enable;
    logic       MDR_Mux_select;
    logic       RAM_enable;
    logic [5:0] RAM_OpCode;
    logic       register_file_enable;
    logic       addr_inc;
    logic       word_sel;
    logic       busy;
    logic       done;
    logic       trap;
    logic [1:0] trap_type;

    modport master (
        output start, op3, addr_lo, MFC,
        input  MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, RAM_OpCode,
               register_file_enable, addr_inc, word_sel, busy, done, trap, trap_type
    );

    modport slave (
        input  start, op3, addr_lo, MFC,
        output MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, RAM_OpCode,
               register_file_enable, addr_inc, word_sel, busy, done, trap, trap_type
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Multi-cycle sequencer for SPARC V8 load/store instructions (byte, half,
//   word, doubleword). Checks op3 legality and address alignment, drives the
//   MAR/MDR/RAM/register-file strobes and waits on the RAM MFC handshake with
//   a timeout. All outputs are registered, decoded from the next state.
//   Ports: Clk (rising edge), Clr (async, active low), bus (slave modport).
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   S_IDLE   | waiting for start; legality/alignment decided here
//   S_MAR    | load MAR with the effective address
//   S_MDRW   | load MDR from register out_PB (stores)
//   S_ACCESS | RAM strobe active, waiting for MFC, timeout counting
//   S_LATCH  | capture RAM data into MDR
//   S_WB     | write MDR back to the register file
//   S_NEXT   | bump address by 4 for the second doubleword half
//   S_DONE   | completion pulse
//   S_TRAP   | trap pulse, trap_type holds the cause
module mem_access_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                  Clk,
    input  logic                  Clr,
    mem_access_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_MAR, S_MDRW, S_ACCESS, S_LATCH, S_WB, S_NEXT, S_DONE, S_TRAP
    } state_t;

    state_t           state, state_nxt;
    logic [5:0]       op_q, op_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       tt_nxt;
    logic             ws_nxt;
    logic             is_store, is_double, timeout_hit;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b001001, 6'b001010,
            6'b000100, 6'b000101, 6'b000110, 6'b000111: op_legal = 1'b1;
            default:                                   op_legal = 1'b0;
        endcase
    endfunction

    // For every legal op3, bits [1:0] encode the size: 00 word, 01 byte,
    // 10 half, 11 double.
    function automatic logic misaligned(input logic [5:0] op, input logic [2:0] a);
        case (op[1:0])
            2'b00:   misaligned = (a[1:0] != 2'b00);
            2'b10:   misaligned = a[0];
            2'b11:   misaligned = (a != 3'b000);
            default: misaligned = 1'b0;
        endcase
    endfunction

    assign is_store    = op_q[2];
    assign is_double   = (op_q[1:0] == 2'b11) && !op_q[3];
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        tt_nxt    = bus.trap_type;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    op_nxt = bus.op3;
                    tt_nxt = 2'b00;
                    if (!op_legal(bus.op3)) begin
                        state_nxt = S_TRAP;
                        tt_nxt    = 2'b10;
                    end else if (misaligned(bus.op3, bus.addr_lo)) begin
                        state_nxt = S_TRAP;
                        tt_nxt    = 2'b01;
                    end else begin
                        state_nxt = S_MAR;
                    end
                end
            end
            S_MAR:  state_nxt = is_store ? S_MDRW : S_ACCESS;
            S_MDRW: state_nxt = S_ACCESS;
            S_ACCESS: begin
                // MFC wins over a timeout landing in the same cycle.
                if (bus.MFC) begin
                    if (!is_store)
                        state_nxt = S_LATCH;
                    else if (is_double && !bus.word_sel)
                        state_nxt = S_NEXT;
                    else
                        state_nxt = S_DONE;
                end else if (timeout_hit) begin
                    state_nxt = S_TRAP;
                    tt_nxt    = 2'b11;
                end
            end
            S_LATCH: state_nxt = S_WB;
            S_WB:    state_nxt = (is_double && !bus.word_sel) ? S_NEXT : S_DONE;
            S_NEXT:  state_nxt = is_store ? S_MDRW : S_ACCESS;
            S_DONE:  state_nxt = S_IDLE;
            S_TRAP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        ws_nxt = bus.word_sel;
        if (state_nxt == S_NEXT)
            ws_nxt = 1'b1;
        else if (state_nxt == S_DONE || state_nxt == S_TRAP)
            ws_nxt = 1'b0;

        // Counter restarts on every entry into ACCESS, including the second
        // doubleword half.
        cnt_nxt = cnt;
        if (state_nxt == S_ACCESS && state != S_ACCESS)
            cnt_nxt = '0;
        else if (state == S_ACCESS)
            cnt_nxt = cnt + CNT_W'(1);
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state                    <= S_IDLE;
            op_q                     <= 6'd0;
            cnt                      <= '0;
            bus.trap_type            <= 2'b00;
            bus.word_sel             <= 1'b0;
            bus.MAR_Enable           <= 1'b0;
            bus.MDR_Enable           <= 1'b0;
            bus.MDR_Mux_select       <= 1'b0;
            bus.RAM_enable           <= 1'b0;
            bus.RAM_OpCode           <= 6'd0;
            bus.register_file_enable <= 1'b0;
            bus.addr_inc             <= 1'b0;
            bus.busy                 <= 1'b0;
            bus.done                 <= 1'b0;
            bus.trap                 <= 1'b0;
        end else begin
            state                    <= state_nxt;
            op_q                     <= op_nxt;
            cnt                      <= cnt_nxt;
            bus.trap_type            <= tt_nxt;
            bus.word_sel             <= ws_nxt;
            bus.MAR_Enable           <= (state_nxt == S_MAR) || (state_nxt == S_NEXT);
            bus.MDR_Enable           <= (state_nxt == S_MDRW) || (state_nxt == S_LATCH);
            bus.MDR_Mux_select       <= (state_nxt == S_LATCH);
            bus.RAM_enable           <= (state_nxt == S_ACCESS) || (state_nxt == S_LATCH);
            bus.RAM_OpCode           <= ((state_nxt == S_ACCESS) || (state_nxt == S_LATCH))
                                        ? op_nxt : 6'd0;
            bus.register_file_enable <= (state_nxt == S_WB);
            bus.addr_inc             <= (state_nxt == S_NEXT);
            bus.busy                 <= (state_nxt != S_IDLE);
            bus.done                 <= (state_nxt == S_DONE);
            bus.trap                 <= (state_nxt == S_TRAP);
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer
//   Directed, table-driven bench for mem_access_sequencer. Each vector issues
//   one memory op, a small MFC responder answers after a programmable delay,
//   and per-op strobe counts, end cycle and trap cause are compared with
//   hand-computed values. Hand sequences cover reset mid-access and a start
//   asserted while busy.
module tb_mem_access_sequencer;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    mem_access_sequencer_if bus();

    mem_access_sequencer #(.TIMEOUT(16), .CNT_W(8)) dut (
        .Clk (clk),
        .Clr (clr),
        .bus (bus)
    );

    typedef struct {
        logic [5:0] op;
        logic [2:0] addr;
        int         dly;
        int         end_cyc;
        int         is_done;
        int         tt;
        int         mar;
        int         ram;
        int         mdrw;
        int         mdrr;
        int         wb;
        int         inc;
        int         ws;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_bad = 0;

    int run, dly;
    int n_mar, n_ram, n_mdrw, n_mdrr, n_wb, n_inc, n_ws, n_operr, pulses;
    int end_cyc, end_done, end_tt, ws_end, last_busy, last_tt;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int out_vec();
        return int'({bus.MAR_Enable, bus.MDR_Enable, bus.MDR_Mux_select, bus.RAM_enable,
                     bus.RAM_OpCode, bus.register_file_enable, bus.addr_inc, bus.word_sel,
                     bus.busy, bus.done, bus.trap, bus.trap_type});
    endfunction

    // Issues start at the next edge; observes cycles 1..end+3.
    // pester != 0 re-asserts start for the edges ending cycle 2 and cycle pester.
    task automatic run_op(input logic [5:0] op, input logic [2:0] addr, input int d,
                          input int pester);
        bus.op3 = op; bus.addr_lo = addr; bus.start = 1'b1; bus.MFC = 1'b0;
        dly = d; run = 0;
        n_mar = 0; n_ram = 0; n_mdrw = 0; n_mdrr = 0; n_wb = 0; n_inc = 0; n_ws = 0;
        n_operr = 0; pulses = 0; end_cyc = -1; end_done = 0; end_tt = 0; ws_end = 0;
        last_busy = 0; last_tt = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            bus.start = (pester != 0) && (c == 2 || c == pester);
            if (bus.MAR_Enable) n_mar++;
            if (bus.RAM_enable) n_ram++;
            if (bus.MDR_Enable && !bus.MDR_Mux_select) n_mdrw++;
            if (bus.MDR_Enable && bus.MDR_Mux_select) n_mdrr++;
            if (bus.register_file_enable) n_wb++;
            if (bus.addr_inc) n_inc++;
            if (bus.RAM_enable && bus.word_sel) n_ws++;
            if (bus.RAM_enable ? (bus.RAM_OpCode != op) : (bus.RAM_OpCode != 6'd0)) n_operr++;
            if (bus.done || bus.trap) begin
                pulses++;
                if (end_cyc < 0) begin
                    end_cyc  = c;
                    end_done = int'(bus.done);
                    end_tt   = int'(bus.trap_type);
                    ws_end   = int'(bus.word_sel);
                end
            end
            if (bus.RAM_enable) run++; else run = 0;
            bus.MFC   = bus.RAM_enable && (run > dly);
            last_busy = int'(bus.busy);
            last_tt   = int'(bus.trap_type);
            if (end_cyc >= 0 && c >= end_cyc + 3) break;
        end
        bus.MFC = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            op         addr dly end done tt mar ram mdrw mdrr wb inc ws
        vecs[0]  = '{6'b000000, 3'd0,   0,  5, 1, 0, 1,  2, 0, 1, 1, 0, 0};
        vecs[1]  = '{6'b000001, 3'd3,   0,  5, 1, 0, 1,  2, 0, 1, 1, 0, 0};
        vecs[2]  = '{6'b000010, 3'd2,   0,  5, 1, 0, 1,  2, 0, 1, 1, 0, 0};
        vecs[3]  = '{6'b001010, 3'd1,   0,  1, 0, 1, 0,  0, 0, 0, 0, 0, 0};
        vecs[4]  = '{6'b000100, 3'd0,   0,  4, 1, 0, 1,  1, 1, 0, 0, 0, 0};
        vecs[5]  = '{6'b000110, 3'd1,   0,  1, 0, 1, 0,  0, 0, 0, 0, 0, 0};
        vecs[6]  = '{6'b000101, 3'd7,   0,  4, 1, 0, 1,  1, 1, 0, 0, 0, 0};
        vecs[7]  = '{6'b000011, 3'd0,   0,  9, 1, 0, 2,  4, 0, 2, 2, 1, 2};
        vecs[8]  = '{6'b000111, 3'd0,   3, 13, 1, 0, 2,  8, 2, 0, 0, 1, 4};
        vecs[9]  = '{6'b000011, 3'd4,   0,  1, 0, 1, 0,  0, 0, 0, 0, 0, 0};
        vecs[10] = '{6'b000100, 3'd2,   0,  1, 0, 1, 0,  0, 0, 0, 0, 0, 0};
        vecs[11] = '{6'b000000, 3'd0, 255, 18, 0, 3, 1, 16, 0, 0, 0, 0, 0};
        vecs[12] = '{6'b111111, 3'd0,   0,  1, 0, 2, 0,  0, 0, 0, 0, 0, 0};
        vecs[13] = '{6'b001011, 3'd1,   0,  1, 0, 2, 0,  0, 0, 0, 0, 0, 0};
        vecs[14] = '{6'b000000, 3'd0,   2,  7, 1, 0, 1,  4, 0, 1, 1, 0, 0};
        vecs[15] = '{6'b000000, 3'd0,  14, 19, 1, 0, 1, 16, 0, 1, 1, 0, 0};
        vecs[16] = '{6'b000000, 3'd0,  15, 20, 1, 0, 1, 17, 0, 1, 1, 0, 0};
        vecs[17] = '{6'b000111, 3'd0,   0,  7, 1, 0, 2,  2, 2, 0, 0, 1, 1};
        vecs[18] = '{6'b000111, 3'd4,   0,  1, 0, 1, 0,  0, 0, 0, 0, 0, 0};

        clr = 1'b0;
        bus.start = 1'b0; bus.op3 = 6'd0; bus.addr_lo = 3'd0; bus.MFC = 1'b0;
        #12;
        check("reset_outputs", out_vec(), 0);
        clr = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].addr, vecs[i].dly, 0);
            check($sformatf("v%0d_end_cycle", i), end_cyc, vecs[i].end_cyc);
            check($sformatf("v%0d_done_not_trap", i), end_done, vecs[i].is_done);
            check($sformatf("v%0d_trap_type", i), end_tt, vecs[i].tt);
            check($sformatf("v%0d_trap_type_held", i), last_tt, vecs[i].tt);
            check($sformatf("v%0d_pulses", i), pulses, 1);
            check($sformatf("v%0d_mar", i), n_mar, vecs[i].mar);
            check($sformatf("v%0d_ram", i), n_ram, vecs[i].ram);
            check($sformatf("v%0d_mdr_from_reg", i), n_mdrw, vecs[i].mdrw);
            check($sformatf("v%0d_mdr_from_ram", i), n_mdrr, vecs[i].mdrr);
            check($sformatf("v%0d_rf_we", i), n_wb, vecs[i].wb);
            check($sformatf("v%0d_addr_inc", i), n_inc, vecs[i].inc);
            check($sformatf("v%0d_word_sel_ram", i), n_ws, vecs[i].ws);
            check($sformatf("v%0d_word_sel_end", i), ws_end, 0);
            check($sformatf("v%0d_opcode_err", i), n_operr, 0);
            check($sformatf("v%0d_idle_busy", i), last_busy, 0);
        end

        // LDSB with start re-asserted while busy and in the DONE cycle.
        run_op(6'b001001, 3'd3, 0, 5);
        check("ldsb_end_cycle", end_cyc, 5);
        check("ldsb_done", end_done, 1);
        check("ldsb_pulses", pulses, 1);
        check("ldsb_ram", n_ram, 2);
        check("ldsb_mar", n_mar, 1);
        check("ldsb_opcode_err", n_operr, 0);
        check("ldsb_idle_busy", last_busy, 0);

        // Reset in the middle of an LD access.
        bus.op3 = 6'b000000; bus.addr_lo = 3'd0; bus.MFC = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("mid_reset_in_access", int'(bus.RAM_enable), 1);
        #2;
        clr = 1'b0;
        #1;
        check("mid_reset_immediate", out_vec(), 0);
        tick();
        check("mid_reset_held", out_vec(), 0);
        #2;
        clr = 1'b1;
        tick();
        tick();
        tick();
        check("after_reset_idle", out_vec(), 0);
        run_op(6'b000000, 3'd0, 0, 0);
        check("after_reset_ld_end", end_cyc, 5);
        check("after_reset_ld_done", end_done, 1);
        check("after_reset_ld_ram", n_ram, 2);
        check("after_reset_ld_wb", n_wb, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Multi-cycle sequencer for SPARC V8 load/store instructions.
- Drives the MAR/MDR enables, the MDR input mux, RAM_enable/RAM_OpCode and the register-file write strobe, and waits on the RAM MFC handshake.
- The ControlUnit hands it one memory op via start/op3 and resumes fetch on done or trap.
- Handles byte, halfword, word and doubleword accesses, alignment checking and an MFC timeout.

Parameters:
- TIMEOUT, 16: max cycles spent in ACCESS without MFC before a timeout trap (legal range 2..255).
- CNT_W, 8: width of the timeout counter.

Ports:
- Clk  input  1  system clock, rising edge.
- Clr  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request from ControlUnit; sampled only in IDLE.
- op3  input  6  IR[24:19] of the memory instruction.
- addr_lo  input  3  effective address bits [2:0] (ALU_Out[2:0]).
- MFC  input  1  memory function complete from RAM.
- MAR_Enable  output  1  load MAR.
- MDR_Enable  output  1  load MDR.
- MDR_Mux_select  output  1  MDR source: 0 = register out_PB, 1 = RAM data.
- RAM_enable  output  1  RAM access strobe.
- RAM_OpCode  output  6  op3 forwarded to RAM during access.
- register_file_enable  output  1  write-back strobe for loads.
- addr_inc  output  1  pulse: datapath adds 4 to the effective address for the second doubleword half.
- word_sel  output  1  0 = even register / first word, 1 = odd register / second word.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- trap  output  1  one-cycle trap pulse.
- trap_type  output  2  01 = mem_address_not_aligned, 10 = illegal op3, 11 = MFC timeout; held until the next start.

Behaviour:
- Legal op3 values:
  - Loads: LD 000000, LDUB 000001, LDUH 000010, LDD 000011, LDSB 001001, LDSH 001010.
  - Stores: ST 000100, STB 000101, STH 000110, STD 000111.
  - Every other code is illegal.
- Store = op3[2]. Double = op3[1:0]==11 and op3[3]==0.
- Reset (Clr=0):
  - Takes effect immediately: state IDLE; all outputs 0; trap_type 00; counter 0; latched op cleared.
  - Reset in the middle of an access abandons it with no done or trap pulse.
- All outputs are registered, Moore-decoded from state; RAM_OpCode = latched op3 in ACCESS/LATCH, else 0.
- IDLE:
  - On start: latch op3 and addr_lo, clear trap_type.
  - Next state: TRAP if illegal op3 (type 10), else TRAP if misaligned (type 01), else MAR. The illegal check has priority over the alignment check.
  - Misaligned means: half with addr_lo[0]!=0; word with addr_lo[1:0]!=0; double with addr_lo[2:0]!=0. Bytes never trap.
- MAR: MAR_Enable=1 for one cycle. Next state is MDRW for a store, ACCESS for a load.
- MDRW: MDR_Mux_select=0, MDR_Enable=1 for one cycle, then ACCESS.
- ACCESS:
  - RAM_enable=1 and the counter increments each cycle; the counter is cleared on entry.
  - MFC=1: a load goes to LATCH; a store goes to NEXT if double and word_sel=0, else DONE.
  - counter==TIMEOUT-1 with MFC=0: TRAP, type 11.
  - MFC has priority over timeout when both occur in the same cycle.
- LATCH: RAM_enable=1 (data held), MDR_Mux_select=1, MDR_Enable=1, then WB.
- WB: register_file_enable=1; next state NEXT if double and word_sel=0, else DONE.
- NEXT:
  - addr_inc=1 and MAR_Enable=1; word_sel toggles to 1.
  - Then MDRW for a store, ACCESS for a load.
  - word_sel returns to 0 on entry to DONE or TRAP.
- DONE: done=1 for one cycle, then IDLE.
- TRAP: trap=1 for one cycle, then IDLE; no RAM or register side effects.
- start asserted outside IDLE is ignored, including in the DONE cycle.
- Latency with MFC returned in the first ACCESS cycle, start sampled at edge 0: word load done in cycle 5; store done in cycle 4; LDD done in cycle 9; STD done in cycle 7.

Test Plan:
- Reset/idle: Clr low mid-ACCESS of an LD -> all outputs 0 immediately; after release busy=0; a start 3 cycles later behaves normally.
- LD, addr_lo=000, MFC tied high -> MAR_Enable in cycle 1, RAM_enable cycles 2-3, MDR_Enable+MDR_Mux_select=1 in cycle 3, register_file_enable cycle 4, done cycle 5.
- STH (op3 000110) with addr_lo=001 -> trap in cycle 1 with trap_type=01; MAR_Enable, RAM_enable and MDR_Enable never assert.
- STD, addr_lo=000, MFC delayed 3 cycles per access:
  - two ACCESS phases, each with RAM_OpCode=000111;
  - addr_inc pulse once between them; word_sel=1 during the second phase;
  - MDR_Mux_select=0 on both MDR loads; done once.
- LD with MFC held low -> trap_type=11 after exactly TIMEOUT ACCESS cycles (16 with defaults); a subsequent start with op3=111111 -> trap_type=10.
- LDSB, addr_lo=011 -> no trap; RAM_OpCode=001001 during access; done in cycle 5; a start pulse during busy is ignored (exactly one done pulse).
